// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO port master: default sizes, FSM states and
// the encoding of the FIFO direction line.
package fifo_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    typedef enum logic {
        RST_HOLD = 1'b0,
        ARB      = 1'b1
    } state_t;

    // Direction line encoding as seen on WRH_RDL
    typedef enum logic {
        DIR_RD = 1'b0,
        DIR_WR = 1'b1
    } dir_t;

endpackage

// File: rtl/fifo_dir_arb.sv
// Direction arbiter for the single WRH_RDL line: picks write or read for the
// current cycle and limits same-direction bursts while both sides have work.
module fifo_dir_arb
    import fifo_pkg::*;
#(
    parameter int BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic s_valid,
    input  logic full,
    input  logic empty,
    output dir_t dir
);

    localparam int CNT_W = $clog2(BURST + 1);

    logic [CNT_W-1:0] burst_cnt;
    dir_t             last_dir;
    logic             wr_want;
    logic             rd_want;

    assign wr_want = s_valid && !full;
    assign rd_want = !empty;

    // Choose the slot direction; idle cycles and a full FIFO fall back to a read slot
    always_comb begin
        dir = DIR_RD;
        if (enable) begin
            if (wr_want && !rd_want) begin
                dir = DIR_WR;
            end else if (wr_want && rd_want) begin
                if (burst_cnt < CNT_W'(BURST)) begin
                    dir = last_dir;
                end else begin
                    dir = (last_dir == DIR_WR) ? DIR_RD : DIR_WR;
                end
            end
        end
    end

    // Track the current direction and how many slots in a row it has had
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
            last_dir  <= DIR_RD;
        end else if (!enable) begin
            burst_cnt <= '0;
            last_dir  <= DIR_RD;
        end else if (dir != last_dir) begin
            burst_cnt <= CNT_W'(1);
            last_dir  <= dir;
        end else if (burst_cnt < CNT_W'(BURST)) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_port_sched.sv
// Port master for the single-direction FIFO: sequences the FIFO reset,
// time-multiplexes WRH_RDL between producer writes and sink pops, and keeps a
// shadow occupancy that is cross-checked against FULL/EMPTY.
module fifo_port_sched
    import fifo_pkg::*;
#(
    parameter int DATA_W = fifo_pkg::DATA_W,
    parameter int DEPTH  = fifo_pkg::DEPTH,
    parameter int BURST  = 4
) (
    input  logic                    CLK,
    input  logic                    RESETL,
    input  logic                    FLUSH,
    input  logic                    S_VALID,
    input  logic [DATA_W-1:0]       S_DATA,
    output logic                    S_READY,
    output logic                    M_VALID,
    output logic [DATA_W-1:0]       M_DATA,
    output logic                    F_RESETH,
    output logic                    F_WRH_RDL,
    output logic [DATA_W-1:0]       F_DATAIN,
    input  logic [DATA_W-1:0]       F_DATAOUT,
    input  logic                    F_FULL,
    input  logic                    F_EMPTY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic [15:0]             WR_CNT,
    output logic [15:0]             RD_CNT,
    output logic                    ERR
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    state_t state;
    logic   hold_cnt;
    dir_t   dir;
    logic   arb_en;
    logic   wr_slot;
    logic   pop;

    assign arb_en = (state == ARB);

    fifo_dir_arb #(
        .BURST (BURST)
    ) u_arb (
        .clk     (CLK),
        .rst_n   (RESETL),
        .enable  (arb_en),
        .s_valid (S_VALID),
        .full    (F_FULL),
        .empty   (F_EMPTY),
        .dir     (dir)
    );

    // A write slot is only ever granted with S_VALID high and FULL low, so it
    // doubles as the handshake; a read slot on an empty FIFO is a no-op.
    assign wr_slot   = arb_en && (dir == DIR_WR);
    assign pop       = arb_en && (dir == DIR_RD) && !F_EMPTY;
    assign S_READY   = wr_slot;
    assign F_WRH_RDL = wr_slot;
    assign F_DATAIN  = S_DATA;
    assign M_DATA    = F_DATAOUT;

    // Reset sequencer: hold FIFO RESETH for two edges after reset release or FLUSH
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            state    <= RST_HOLD;
            hold_cnt <= 1'b0;
            F_RESETH <= 1'b1;
        end else if (FLUSH) begin
            state    <= RST_HOLD;
            hold_cnt <= 1'b0;
            F_RESETH <= 1'b1;
        end else if (state == RST_HOLD) begin
            if (hold_cnt) begin
                state    <= ARB;
                hold_cnt <= 1'b0;
                F_RESETH <= 1'b0;
            end else begin
                hold_cnt <= 1'b1;
            end
        end
    end

    // Pop latency, shadow level, traffic counters and the sticky consistency flag
    always_ff @(posedge CLK or negedge RESETL) begin
        if (!RESETL) begin
            M_VALID <= 1'b0;
            LEVEL   <= '0;
            WR_CNT  <= '0;
            RD_CNT  <= '0;
            ERR     <= 1'b0;
        end else begin
            M_VALID <= pop;
            if (wr_slot) begin
                WR_CNT <= WR_CNT + 16'd1;
            end
            if (pop) begin
                RD_CNT <= RD_CNT + 16'd1;
            end
            if (FLUSH || (state == RST_HOLD)) begin
                LEVEL <= '0;
                ERR   <= 1'b0;
            end else begin
                if (wr_slot) begin
                    LEVEL <= LEVEL + LVL_W'(1);
                end else if (pop) begin
                    LEVEL <= LEVEL - LVL_W'(1);
                end
                if (((LEVEL == '0) != F_EMPTY) || ((LEVEL == LVL_W'(DEPTH)) != F_FULL)) begin
                    ERR <= 1'b1;
                end
            end
        end
    end

endmodule
